// File: rtl/multiplicador_booth_pkg.sv
// Shared multiply/divide datapath constants: operand width, multiplier FSM
// state encoding and the Booth step opcodes with their decode helper.
// No ports; imported by the multiplier, its step logic and its interface users.
package multiplicador_booth_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the pair {Q[0], q_m1}:
    // 01 ends a run of ones (add), 10 starts one (subtract), 00/11 do nothing.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   booth_decode = BOOTH_ADD;
            2'b10:   booth_decode = BOOTH_SUB;
            default: booth_decode = BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multiplicador_booth_if.sv
// Control-side bundle of the multiplier: start strobe plus operands going in,
// product halves and status coming back.
// master = control unit (drives mult_start/A/B), slave = multiplier.
interface multiplicador_booth_if #(
    parameter int WIDTH = 32
);
    logic             mult_start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output mult_start, A, B,
        input  hi, lo, busy, done
    );

    modport slave (
        input  mult_start, A, B,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/multiplicador_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then arithmetic shift.
// Latency: combinational. Backpressure: none.
// Ports: cur = {Acc, Q, q_m1} in, m = multiplicand, nxt = shifted {Acc, Q, q_m1}.
module multiplicador_booth_step
    import multiplicador_booth_pkg::*;
#(
    parameter int WIDTH = multiplicador_booth_pkg::WIDTH
) (
    input  logic [2*WIDTH+1:0] cur,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH+1:0] nxt
);

    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH-1:0] q;
    logic             q_m1;

    assign {acc, q, q_m1} = cur;

    // Acc is one bit wider than M so that -(-2^(W-1)) stays representable.
    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        acc_n = acc;
        case (booth_decode(q[0], q_m1))
            BOOTH_ADD: acc_n = acc + m_ext;
            BOOTH_SUB: acc_n = acc - m_ext;
            default:   acc_n = acc;
        endcase
    end

    // Arithmetic right shift of {acc_n, q, q_m1}: old q_m1 falls off the end.
    assign nxt = {acc_n[WIDTH], acc_n, q};

endmodule

// File: rtl/multiplicador_booth.sv
// Sequential signed WIDTHxWIDTH -> 2*WIDTH Booth multiplier producing HI/LO.
// Latency: start sampled at edge k, hi/lo/done valid after edge k+ITER+1.
// Backpressure: mult_start ignored while busy; no queueing of requests.
// Ports: clock, reset (sync, active-high), bus (slave: mult_start/A/B in, hi/lo/busy/done out).
module multiplicador_booth
    import multiplicador_booth_pkg::*;
#(
    parameter int WIDTH = multiplicador_booth_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    multiplicador_booth_if.slave  bus
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_t             state;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               done;
    logic [2*WIDTH+1:0] step_nxt;

    multiplicador_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .cur (({acc, q, q_m1})),
        .m   (m),
        .nxt (step_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            m     <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.mult_start) begin
                        m     <= bus.A;
                        q     <= bus.B;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    {acc, q, q_m1} <= step_nxt;
                    cnt            <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Acc[WIDTH] is only a guard bit; the product is {Acc[W-1:0], Q}.
                    hi    <= acc[WIDTH-1:0];
                    lo    <= q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = hi;
    assign bus.lo   = lo;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule

// File: tb/tb_multiplicador_booth.sv
// Bench for multiplicador_booth: directed corner cases plus random operands,
// checked against a plain 64-bit signed product and cycle-accurate latency.
module tb_multiplicador_booth;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    multiplicador_booth_if #(.WIDTH(32)) bus ();

    multiplicador_booth #(.WIDTH(32), .ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Count done-high cycles, sampled mid-cycle.
    always @(negedge clock) if (bus.done === 1'b1) done_cnt++;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse mult_start for one edge, then wait (bounded) for done.
    // lat = number of edges after the start edge until done is seen; 0 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        bus.A = a;
        bus.B = b;
        bus.mult_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.mult_start = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic op_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [63:0] exp;
        exp = ref_mul(a, b);
        run_op(a, b, lat);
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
    endtask

    initial begin
        int          lat;
        int          d0;
        int          t1;
        int          t2;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.mult_start = 1'b0;
        bus.A = '0;
        bus.B = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);

        // 3*5 with done/busy timing around the result cycle
        run_op(32'd3, 32'd5, lat);
        check("3x5 latency", 64'(lat), 64'd33);
        check("3x5 hi", 64'(bus.hi), 64'h0);
        check("3x5 lo", 64'(bus.lo), 64'hF);
        check("3x5 busy with done", 64'(bus.busy), 64'd0);
        @(negedge clock);
        check("3x5 done one cycle", 64'(bus.done), 64'd0);
        check("3x5 busy after", 64'(bus.busy), 64'd0);

        // Sign handling and widened accumulator corners
        op_and_check("-7x6", 32'hFFFFFFF9, 32'd6);
        op_and_check("minxmin", 32'h80000000, 32'h80000000);
        op_and_check("maxxmax", 32'h7FFFFFFF, 32'h7FFFFFFF);
        op_and_check("0xB", 32'd0, 32'h12345678);
        op_and_check("minx-1", 32'h80000000, 32'hFFFFFFFF);
        op_and_check("Ax0", 32'hDEADBEEF, 32'd0);

        // busy stays high through the whole operation
        @(negedge clock);
        bus.A = 32'd4;
        bus.B = 32'd4;
        bus.mult_start = 1'b1;
        @(negedge clock);
        bus.mult_start = 1'b0;
        repeat (20) @(negedge clock);
        check("busy mid run", 64'(bus.busy), 64'd1);
        for (int n = 0; n < 40 && bus.done !== 1'b1; n++) @(negedge clock);
        check("4x4 lo", 64'(bus.lo), 64'd16);

        // Second start while busy is ignored
        @(negedge clock);
        d0 = done_cnt;
        bus.A = 32'd9;
        bus.B = 32'd9;
        bus.mult_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.mult_start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 10) begin
                bus.A = 32'd2;
                bus.B = 32'd2;
                bus.mult_start = 1'b1;
            end else begin
                bus.mult_start = 1'b0;
            end
            @(negedge clock);
            if (bus.done === 1'b1 && lat == 0) lat = n;
        end
        check("ignored start latency", 64'(lat), 64'd33);
        check("ignored start hi", 64'(bus.hi), 64'h0);
        check("ignored start lo", 64'(bus.lo), 64'h51);
        check("ignored start done pulses", 64'(done_cnt - d0), 64'd1);

        // Reset in the middle of RUN aborts without a done pulse
        @(negedge clock);
        bus.A = 32'd1234;
        bus.B = 32'd5678;
        bus.mult_start = 1'b1;
        @(negedge clock);
        bus.mult_start = 1'b0;
        repeat (14) @(negedge clock);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("abort done pulses", 64'(done_cnt - d0), 64'd0);
        check("abort hi", 64'(bus.hi), 64'd0);
        check("abort lo", 64'(bus.lo), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        op_and_check("-1x-1", 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("-1x-1 lo const", 64'(bus.lo), 64'd1);

        // mult_start held high restarts every time IDLE is re-entered
        @(negedge clock);
        bus.A = 32'hFFFFFFFD;
        bus.B = 32'd11;
        bus.mult_start = 1'b1;
        t1 = 0;
        t2 = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                if (t1 == 0) t1 = n;
                else begin
                    t2 = n;
                    bus.mult_start = 1'b0;
                    break;
                end
            end
        end
        check("held start period", 64'(t2 - t1), 64'd34);
        check("held start lo", 64'(bus.lo), 64'hFFFFFFDF);
        @(negedge clock);
        check("held start released", 64'(bus.busy), 64'd0);

        // Random operands against the reference product
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h80000000;
            if (i == 1) rb = 32'h80000000;
            op_and_check($sformatf("rand%0d", i), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
